// File: rtl/opex_stage.sv
// rtl/opex_stage.sv - OP->EX pipeline register with MA/WB forwarding and an iterative radix-2 divider
module opex_stage #(
   parameter int XLEN     = 32,
   parameter int DIV_ITER = 32,
   parameter int ICTRL_W  = 4,
   parameter int F_W      = 10,
   parameter int RF_W     = 5
)(
   input  logic               s_clk_i,
   input  logic               s_reset_i,
   input  logic [XLEN-1:0]    s_operand1_i,
   input  logic [XLEN-1:0]    s_operand2_i,
   input  logic [3:0]         s_fwd_i,
   input  logic               s_bubble_i,
   input  logic [ICTRL_W-1:0] s_idop_ictrl_i,
   input  logic [F_W-1:0]     s_idop_f_i,
   input  logic [RF_W-1:0]    s_idop_rd_i,
   input  logic               s_idop_div_i,
   input  logic [XLEN-1:0]    s_exma_val_i,
   input  logic [XLEN-1:0]    s_mawb_val_i,
   input  logic               s_hold_i,
   input  logic               s_flush_i,
   output logic [XLEN-1:0]    s_opex_op1_o,
   output logic [XLEN-1:0]    s_opex_op2_o,
   output logic [ICTRL_W-1:0] s_opex_ictrl_o,
   output logic [F_W-1:0]     s_opex_f_o,
   output logic [RF_W-1:0]    s_opex_rd_o,
   output logic               s_div_busy_o,
   output logic               s_div_valid_o,
   output logic [XLEN-1:0]    s_div_res_o
);

   localparam int CW = $clog2(DIV_ITER);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state;
   logic [XLEN-1:0]    op1_q, op2_q;
   logic [ICTRL_W-1:0] ictrl_q;
   logic [F_W-1:0]     f_q;
   logic [RF_W-1:0]    rd_q;
   logic               div_q;
   logic [3:0]         fwd_q;

   logic [XLEN-1:0]    quo_q, rem_q, dvs_q;
   logic               quo_neg_q, rem_neg_q, valid_q;
   logic [CW-1:0]      cnt_q;

   logic [XLEN-1:0]    op1_r, op2_r;
   logic               ex_div, busy, load;
   logic               signed_op, div_zero, overflow;
   logic [XLEN-1:0]    abs1, abs2;
   logic [XLEN:0]      rem_sh;
   logic               ge;
   logic [XLEN-1:0]    rem_nx;
   logic [XLEN-1:0]    quo_fix, rem_fix;

   // fwd_q is cleared after the first EX cycle, so forwarding applies only then
   always_comb begin
      op1_r = op1_q;
      if (fwd_q[0])
         op1_r = s_exma_val_i;
      else if (fwd_q[2])
         op1_r = s_mawb_val_i;
      op2_r = op2_q;
      if (fwd_q[1])
         op2_r = s_exma_val_i;
      else if (fwd_q[3])
         op2_r = s_mawb_val_i;
   end

   assign ex_div    = (|ictrl_q) & div_q;
   assign busy      = ex_div & (state != DONE);
   assign load      = ~s_hold_i & ~busy;

   assign signed_op = ~f_q[0];
   assign abs1      = (signed_op & op1_r[XLEN-1]) ? -op1_r : op1_r;
   assign abs2      = (signed_op & op2_r[XLEN-1]) ? -op2_r : op2_r;
   assign div_zero  = (op2_r == '0);
   assign overflow  = signed_op & (op1_r == {1'b1, {(XLEN-1){1'b0}}}) & (&op2_r);

   // Restoring step; the shifted-out MSB forces a subtract since then rem_sh >= 2^XLEN > divisor
   assign rem_sh = {rem_q, quo_q[XLEN-1]};
   assign ge     = rem_sh[XLEN] | (rem_sh[XLEN-1:0] >= dvs_q);
   assign rem_nx = ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];

   assign quo_fix = quo_neg_q ? -quo_q : quo_q;
   assign rem_fix = rem_neg_q ? -rem_q : rem_q;

   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         op1_q   <= '0;
         op2_q   <= '0;
         ictrl_q <= '0;
         f_q     <= '0;
         rd_q    <= '0;
         div_q   <= 1'b0;
         fwd_q   <= '0;
      end else if (s_flush_i) begin
         ictrl_q <= '0;
         fwd_q   <= '0;
      end else if (load) begin
         op1_q   <= s_operand1_i;
         op2_q   <= s_operand2_i;
         ictrl_q <= s_bubble_i ? '0 : s_idop_ictrl_i;
         fwd_q   <= s_bubble_i ? '0 : s_fwd_i;
         f_q     <= s_idop_f_i;
         rd_q    <= s_idop_rd_i;
         div_q   <= s_idop_div_i;
      end else begin
         // Keep the operands resolved in the first EX cycle while EX is held
         op1_q <= op1_r;
         op2_q <= op2_r;
         fwd_q <= '0;
      end
   end

   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         state     <= IDLE;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
      end else if (s_flush_i) begin
         state   <= IDLE;
         valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ex_div) begin
                  quo_neg_q <= signed_op & (op1_r[XLEN-1] ^ op2_r[XLEN-1]);
                  rem_neg_q <= signed_op & op1_r[XLEN-1];
                  if (div_zero) begin
                     quo_q     <= '1;
                     rem_q     <= op1_r;
                     quo_neg_q <= 1'b0;
                     rem_neg_q <= 1'b0;
                     valid_q   <= 1'b1;
                     state     <= DONE;
                  end else if (overflow) begin
                     quo_q     <= {1'b1, {(XLEN-1){1'b0}}};
                     rem_q     <= '0;
                     quo_neg_q <= 1'b0;
                     rem_neg_q <= 1'b0;
                     valid_q   <= 1'b1;
                     state     <= DONE;
                  end else begin
                     quo_q <= abs1;
                     rem_q <= '0;
                     dvs_q <= abs2;
                     cnt_q <= CW'(DIV_ITER - 1);
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               quo_q <= {quo_q[XLEN-2:0], ge};
               rem_q <= rem_nx;
               if (cnt_q == '0) begin
                  valid_q <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (!s_hold_i) begin
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign s_opex_op1_o   = op1_r;
   assign s_opex_op2_o   = op2_r;
   assign s_opex_ictrl_o = ictrl_q;
   assign s_opex_f_o     = f_q;
   assign s_opex_rd_o    = rd_q;
   assign s_div_busy_o   = busy;
   assign s_div_valid_o  = valid_q;
   assign s_div_res_o    = !valid_q ? '0 : (f_q[1] ? rem_fix : quo_fix);

endmodule

// File: tb/tb_opex_stage.sv
// tb/tb_opex_stage.sv - directed bench for opex_stage with a behavioural reference model
module tb_opex_stage;

   logic        clk, rst;
   logic [31:0] operand1, operand2, exma_val, mawb_val;
   logic [3:0]  fwd;
   logic        bubble, idop_div, hold, flush;
   logic [3:0]  idop_ictrl;
   logic [9:0]  idop_f;
   logic [4:0]  idop_rd;
   logic [31:0] opex_op1, opex_op2, div_res;
   logic [3:0]  opex_ictrl;
   logic [9:0]  opex_f;
   logic [4:0]  opex_rd;
   logic        div_busy, div_valid;

   int n_cmp = 0;
   int n_err = 0;

   opex_stage dut (
      .s_clk_i(clk), .s_reset_i(rst),
      .s_operand1_i(operand1), .s_operand2_i(operand2), .s_fwd_i(fwd),
      .s_bubble_i(bubble), .s_idop_ictrl_i(idop_ictrl), .s_idop_f_i(idop_f),
      .s_idop_rd_i(idop_rd), .s_idop_div_i(idop_div),
      .s_exma_val_i(exma_val), .s_mawb_val_i(mawb_val),
      .s_hold_i(hold), .s_flush_i(flush),
      .s_opex_op1_o(opex_op1), .s_opex_op2_o(opex_op2), .s_opex_ictrl_o(opex_ictrl),
      .s_opex_f_o(opex_f), .s_opex_rd_o(opex_rd),
      .s_div_busy_o(div_busy), .s_div_valid_o(div_valid), .s_div_res_o(div_res)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: the instruction in EX, its age in EX cycles, and its arithmetic result
   typedef struct packed {
      logic [3:0]  ictrl;
      logic [9:0]  f;
      logic [4:0]  rd;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  fwd;
      logic        isdiv;
      int          age;
      int          blen;
      logic [31:0] res;
   } mdl_t;

   mdl_t m;

   function automatic logic [31:0] div_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
      if (!f3[0]) return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return f3[1] ? a % b : a / b;
   endfunction

   function automatic logic m_div(input mdl_t c);
      return (c.ictrl != 4'd0) && c.isdiv;
   endfunction

   function automatic logic m_busy(input mdl_t c);
      return m_div(c) && (c.age == 0 || c.age < c.blen);
   endfunction

   function automatic logic m_valid(input mdl_t c);
      return m_div(c) && c.age > 0 && c.age >= c.blen;
   endfunction

   function automatic logic [31:0] m_op(input mdl_t c, input logic first, input logic ma, input logic wb,
                                        input logic [31:0] lat);
      if (first && ma) return exma_val;
      if (first && wb) return mawb_val;
      return lat;
   endfunction

   function automatic mdl_t mstep(input mdl_t c);
      mdl_t n;
      logic [31:0] r1, r2;
      n  = c;
      r1 = m_op(c, c.age == 0, c.fwd[0], c.fwd[2], c.op1);
      r2 = m_op(c, c.age == 0, c.fwd[1], c.fwd[3], c.op2);
      if (m_div(c) && c.age == 0) begin
         n.res  = div_ref(c.f[2:0], r1, r2);
         n.blen = (r2 == 32'd0 || (!c.f[0] && r1 == 32'h8000_0000 && r2 == 32'hFFFF_FFFF)) ? 1 : 33;
      end
      n.op1 = r1;
      n.op2 = r2;
      if (c.age < 1000) n.age = c.age + 1;
      if (flush) begin
         n.ictrl = 4'd0;
         n.fwd   = 4'd0;
      end else if (!hold && !m_busy(c)) begin
         n.ictrl = bubble ? 4'd0 : idop_ictrl;
         n.fwd   = bubble ? 4'd0 : fwd;
         n.isdiv = idop_div;
         n.op1   = operand1;
         n.op2   = operand2;
         n.f     = idop_f;
         n.rd    = idop_rd;
         n.age   = 0;
         n.blen  = 33;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '0;
      else     m <= mstep(m);
   end

   always @(negedge clk) begin
      chk("busy", 32'(div_busy), 32'(m_busy(m)));
      chk("valid", 32'(div_valid), 32'(m_valid(m)));
      chk("ictrl", 32'(opex_ictrl), 32'(m.ictrl));
      if (m.ictrl != 4'd0) begin
         chk("op1", opex_op1, m_op(m, m.age == 0, m.fwd[0], m.fwd[2], m.op1));
         chk("op2", opex_op2, m_op(m, m.age == 0, m.fwd[1], m.fwd[3], m.op2));
         chk("f", 32'(opex_f), 32'(m.f));
         chk("rd", 32'(opex_rd), 32'(m.rd));
      end
      if (m_valid(m)) chk("res", div_res, m.res);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [3:0] ic, input logic [2:0] f3, input logic [4:0] rd, input logic dv,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] fw, input logic bub);
      idop_ictrl = ic;
      idop_f     = {7'd0, f3};
      idop_rd    = rd;
      idop_div   = dv;
      operand1   = a;
      operand2   = b;
      fwd        = fw;
      bubble     = bub;
   endtask

   task automatic idle();
      present(4'd0, 3'd0, 5'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
   endtask

   task automatic run_div(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] fw, input logic [31:0] exp_res, input int exp_cyc, input int hold_n);
      int cyc, nbusy;
      logic found;
      found = 1'b0;
      cyc   = 0;
      nbusy = 0;
      present(4'd1, f3, 5'd7, 1'b1, a, b, fw, 1'b0);
      tick();
      idle();
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (div_busy) nbusy++;
         if (div_valid) begin
            found = 1'b1;
            cyc   = i;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk({nm, "_done"}, 32'(found), 32'd1);
      if (found) begin
         chk({nm, "_lat"}, 32'(cyc), 32'(exp_cyc));
         chk({nm, "_busycyc"}, 32'(nbusy), 32'(exp_cyc - 1));
         chk({nm, "_res"}, div_res, exp_res);
         if (hold_n > 0) begin
            hold = 1'b1;
            for (int k = 0; k < hold_n; k++) begin
               @(negedge clk);
               chk({nm, "_hvalid"}, 32'(div_valid), 32'd1);
               chk({nm, "_hres"}, div_res, exp_res);
            end
            hold = 1'b0;
         end
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      hold = 1'b0;
      flush = 1'b0;
      exma_val = 32'd0;
      mawb_val = 32'd0;
      idle();
      @(negedge clk);
      chk("rst_busy", 32'(div_busy), 32'd0);
      chk("rst_valid", 32'(div_valid), 32'd0);
      chk("rst_ictrl", 32'(opex_ictrl), 32'd0);
      chk("rst_res", div_res, 32'd0);
      chk("rst_op1", opex_op1, 32'd0);
      chk("rst_op2", opex_op2, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Forwarding
      exma_val = 32'h11;
      mawb_val = 32'h22;
      present(4'd2, 3'd0, 5'd4, 1'b0, 32'hA1, 32'hB2, 4'b0101, 1'b0);
      tick();
      @(negedge clk);
      chk("fwd0101_op1", opex_op1, 32'h11);
      chk("fwd0101_op2", opex_op2, 32'hB2);
      present(4'd2, 3'd0, 5'd4, 1'b0, 32'hC3, 32'hD4, 4'b1000, 1'b0);
      tick();
      @(negedge clk);
      chk("fwd1000_op1", opex_op1, 32'hC3);
      chk("fwd1000_op2", opex_op2, 32'h22);
      present(4'd2, 3'd0, 5'd4, 1'b0, 32'hE5, 32'hF6, 4'b0000, 1'b0);
      tick();
      @(negedge clk);
      chk("fwd0000_op1", opex_op1, 32'hE5);
      chk("fwd0000_op2", opex_op2, 32'hF6);
      chk("nondiv_busy", 32'(div_busy), 32'd0);
      tick();

      // Bubble
      present(4'd5, 3'd0, 5'd3, 1'b0, 32'h1, 32'h2, 4'b0011, 1'b1);
      tick();
      @(negedge clk);
      chk("bubble_ictrl", 32'(opex_ictrl), 32'd0);
      idle();
      tick();

      // Divides
      run_div("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 4'd0, 32'hFFFF_FFFD, 34, 0);
      run_div("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 4'd0, 32'hFFFF_FFFF, 34, 0);
      run_div("divu_max", 3'b101, 32'hFFFF_FFFF, 32'h10, 4'd0, 32'h0FFF_FFFF, 34, 0);
      run_div("div_zero", 3'b100, 32'd9, 32'd0, 4'd0, 32'hFFFF_FFFF, 2, 0);
      run_div("remu_zero", 3'b111, 32'd5, 32'd0, 4'd0, 32'd5, 2, 0);
      run_div("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 32'h8000_0000, 2, 0);
      run_div("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, 32'd0, 2, 0);
      exma_val = 32'd200;
      mawb_val = 32'd0;
      run_div("div_fwdma", 3'b100, 32'd9, 32'd7, 4'b0001, 32'd28, 34, 0);
      run_div("div_fwdwb0", 3'b100, 32'd200, 32'd5, 4'b1000, 32'hFFFF_FFFF, 2, 0);
      run_div("hold_done", 3'b101, 32'd1000, 32'd7, 4'd0, 32'd142, 34, 3);

      // Reset during CALC cycle 10
      present(4'd1, 3'b100, 5'd7, 1'b1, 32'hFFFF_FF9C, 32'd7, 4'd0, 1'b0);
      tick();
      idle();
      repeat (10) tick();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 32'(div_busy), 32'd0);
      chk("midrst_valid", 32'(div_valid), 32'd0);
      chk("midrst_ictrl", 32'(opex_ictrl), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      run_div("after_rst", 3'b100, 32'hFFFF_FF9C, 32'd7, 4'd0, 32'hFFFF_FFF2, 34, 0);

      // Flush during CALC
      present(4'd1, 3'b100, 5'd7, 1'b1, 32'd100, 32'd3, 4'd0, 1'b0);
      tick();
      idle();
      repeat (4) tick();
      present(4'd2, 3'd0, 5'd9, 1'b0, 32'h55, 32'h66, 4'd0, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", 32'(div_busy), 32'd0);
      chk("flush_valid", 32'(div_valid), 32'd0);
      chk("flush_ictrl", 32'(opex_ictrl), 32'd0);
      tick();
      idle();
      @(negedge clk);
      chk("postflush_ictrl", 32'(opex_ictrl), 32'd2);
      chk("postflush_op1", opex_op1, 32'h55);
      tick();
      run_div("after_flush", 3'b100, 32'd100, 32'd7, 4'd0, 32'd14, 34, 0);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
